// File: rtl/tri_press_pkg.sv
// Shared types for the three-button press stretcher: channel IDs, FSM states, counter sizing.
package tri_press_pkg;

   typedef logic [1:0] ch_id_t;

   typedef enum logic [1:0] {
      IDLE,
      ARM,
      HOLD,
      GAP
   } state_t;

   localparam ch_id_t CH_NONE = 2'd3;

   // Width of a counter that must hold values 0..max(hold,gap).
   function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
      int unsigned m;
      m = (hold > gap) ? hold : gap;
      return (m + 1 <= 2) ? 1 : $clog2(m + 1);
   endfunction

endpackage

// File: rtl/press_queue.sv
// Synchronous FIFO of channel IDs with show-ahead read data and wrap-bit pointers.
module press_queue
   import tri_press_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_push,
   input  ch_id_t i_data,
   input  logic   i_pop,
   output ch_id_t o_data,
   output logic   o_full,
   output logic   o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [AW:0] r_wr_ptr;
   logic [AW:0] r_rd_ptr;
   ch_id_t      r_mem [DEPTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_data;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                    (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);

endmodule

// File: rtl/tri_press_stretcher.sv
// Turns single-cycle press requests into queued, tick-aligned, mutually exclusive holds.
// Optional STRETCH_REPEAT_EN: a repeat request for the held channel restarts the hold instead of queuing.
module tri_press_stretcher
   import tri_press_pkg::*;
#(
   parameter int unsigned TICK_W     = 21,
   parameter int unsigned HOLD_TICKS = 3,
   parameter int unsigned GAP_TICKS  = 3,
   parameter int unsigned QDEPTH     = 4
) (
   input  logic sysclk,
   input  logic reset,
   input  logic X0_req,
   input  logic X1_req,
   input  logic X2_req,
   output logic X0_out,
   output logic X1_out,
   output logic X2_out,
   output logic busy,
   output logic collision,
   output logic overflow
);

   localparam int unsigned CW = cnt_width(HOLD_TICKS, GAP_TICKS);

   logic [TICK_W-1:0] r_presc;
   state_t            r_state;
   state_t            w_next_state;
   ch_id_t            r_cur_ch;
   ch_id_t            w_cur_next;
   logic [CW-1:0]     r_cnt;
   logic [CW-1:0]     w_cnt_next;
   logic [2:0]        r_out;
   logic [2:0]        w_out_next;
   logic              r_collision;
   logic              r_overflow;

   logic   w_tick;
   logic   w_req_valid;
   logic   w_collision;
   ch_id_t w_req_ch;
   logic   w_repeat;
   logic   w_push;
   logic   w_pop;
   logic   w_overflow;
   logic   w_q_full;
   logic   w_q_empty;
   ch_id_t w_q_data;

   assign w_tick = &r_presc;

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) r_presc <= '0;
      else        r_presc <= r_presc + TICK_W'(1);
   end

   always_comb begin
      w_req_valid = 1'b0;
      w_collision = 1'b0;
      w_req_ch    = CH_NONE;
      case ({X2_req, X1_req, X0_req})
         3'b000:  ;
         3'b001:  begin w_req_valid = 1'b1; w_req_ch = 2'd0; end
         3'b010:  begin w_req_valid = 1'b1; w_req_ch = 2'd1; end
         3'b100:  begin w_req_valid = 1'b1; w_req_ch = 2'd2; end
         default: w_collision = 1'b1;
      endcase
   end

`ifdef STRETCH_REPEAT_EN
   assign w_repeat = w_req_valid && (r_state == HOLD) && (w_req_ch == r_cur_ch);
`else
   assign w_repeat = 1'b0;
`endif

   // A full queue still accepts a push when the head leaves on the same edge.
   assign w_push     = w_req_valid && !w_repeat && (!w_q_full || w_pop);
   assign w_overflow = w_req_valid && !w_repeat && w_q_full && !w_pop;

   press_queue #(.DEPTH(QDEPTH)) u_queue (
      .i_clk   (sysclk),
      .i_rst_n (reset),
      .i_push  (w_push),
      .i_data  (w_req_ch),
      .i_pop   (w_pop),
      .o_data  (w_q_data),
      .o_full  (w_q_full),
      .o_empty (w_q_empty)
   );

   always_ff @(posedge sysclk or negedge reset) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cur_ch    <= CH_NONE;
         r_cnt       <= '0;
         r_out       <= '0;
         r_collision <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state     <= w_next_state;
         r_cur_ch    <= w_cur_next;
         r_cnt       <= w_cnt_next;
         r_out       <= w_out_next;
         r_collision <= w_collision;
         r_overflow  <= w_overflow;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_cur_next   = r_cur_ch;
      w_cnt_next   = r_cnt;
      w_out_next   = r_out;
      w_pop        = 1'b0;
      case (r_state)
         IDLE: begin
            if (!w_q_empty) begin
               w_pop        = 1'b1;
               w_cur_next   = w_q_data;
               w_next_state = ARM;
            end
         end
         ARM: begin
            if (w_tick) begin
               w_out_next   = 3'b001 << r_cur_ch;
               w_cnt_next   = '0;
               w_next_state = HOLD;
            end
         end
         HOLD: begin
            if (w_repeat) begin
               w_cnt_next = '0;
            end else if (w_tick) begin
               if (r_cnt == CW'(HOLD_TICKS - 1)) begin
                  w_out_next   = '0;
                  w_cnt_next   = '0;
                  w_next_state = (GAP_TICKS == 0) ? IDLE : GAP;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         GAP: begin
            if (w_tick) begin
               if (r_cnt == CW'(GAP_TICKS - 1)) begin
                  w_cnt_next   = '0;
                  w_next_state = IDLE;
               end else begin
                  w_cnt_next = r_cnt + 1'b1;
               end
            end
         end
         default: w_next_state = IDLE;
      endcase
   end

   assign X0_out    = r_out[0];
   assign X1_out    = r_out[1];
   assign X2_out    = r_out[2];
   assign busy      = (r_state != IDLE) || !w_q_empty;
   assign collision = r_collision;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_tri_press_stretcher.sv
// Scoreboard bench for tri_press_stretcher: stimulus pushes expected holds/pulses, a negedge monitor pops them.
module tb_tri_press_stretcher;

   localparam int TICK_W     = 2;
   localparam int HOLD_TICKS = 3;
   localparam int GAP_TICKS  = 2;
   localparam int QDEPTH     = 4;
   localparam int TICK_CYC   = 1 << TICK_W;
   localparam int HOLD_LEN   = HOLD_TICKS * TICK_CYC;
   // Low time between back-to-back holds: the gap ticks plus one tick waiting in ARM.
   localparam int GAP_LEN    = (GAP_TICKS + 1) * TICK_CYC;

   logic sysclk = 1'b0;
   logic reset  = 1'b0;
   logic X0_req = 1'b0, X1_req = 1'b0, X2_req = 1'b0;
   logic X0_out, X1_out, X2_out, busy, collision, overflow;
   logic [2:0] outs;

   assign outs = {X2_out, X1_out, X0_out};

   always #5 sysclk = ~sysclk;

   tri_press_stretcher #(
      .TICK_W     (TICK_W),
      .HOLD_TICKS (HOLD_TICKS),
      .GAP_TICKS  (GAP_TICKS),
      .QDEPTH     (QDEPTH)
   ) dut (
      .sysclk    (sysclk),
      .reset     (reset),
      .X0_req    (X0_req),
      .X1_req    (X1_req),
      .X2_req    (X2_req),
      .X0_out    (X0_out),
      .X1_out    (X1_out),
      .X2_out    (X2_out),
      .busy      (busy),
      .collision (collision),
      .overflow  (overflow)
   );

   typedef struct {
      int ch;
      int len;   // 0: hold is cut by reset, length not checked
   } hold_t;

   hold_t exp_hold[$];
   int    exp_coll[$];
   int    exp_ovf[$];
   int    checks   = 0;
   int    failures = 0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic push_hold(input int ch, input int len);
      hold_t h;
      h.ch  = ch;
      h.len = len;
      exp_hold.push_back(h);
   endtask

   // Monitor
   int cur_ch   = -1;
   int cur_len  = 0;
   int exp_len  = 0;
   int gap_cnt  = 0;
   bit had_hold = 1'b0;
   bit gap_busy = 1'b0;

   always @(negedge sysclk) begin
      if (!reset) begin
         cur_ch   = -1;
         had_hold = 1'b0;
      end else begin
         check("onehot", ($countones(outs) <= 1) ? 1 : 0, 1);
         if (cur_ch < 0 && outs != 3'b000) begin
            cur_ch  = outs[2] ? 2 : (outs[1] ? 1 : 0);
            cur_len = 1;
            checks++;
            if (exp_hold.size() == 0) begin
               failures++;
               $display("FAIL unexpected_hold: got channel %0d, expected none", cur_ch);
               exp_len = 0;
            end else begin
               hold_t h;
               h = exp_hold.pop_front();
               if (h.ch != cur_ch) begin
                  failures++;
                  $display("FAIL hold_ch: got %0d, expected %0d", cur_ch, h.ch);
               end
               exp_len = h.len;
            end
            if (had_hold && gap_busy) check("gap_len", gap_cnt, GAP_LEN);
         end else if (cur_ch >= 0) begin
            if (outs[cur_ch]) cur_len++;
            else begin
               if (exp_len != 0) check("hold_len", cur_len, exp_len);
               cur_ch   = -1;
               had_hold = 1'b1;
               gap_busy = 1'b1;
               gap_cnt  = 0;
            end
         end
         if (cur_ch < 0 && had_hold) begin
            if (!busy) gap_busy = 1'b0;
            gap_cnt++;
         end
         if (collision) begin
            checks++;
            if (exp_coll.size() == 0) begin
               failures++;
               $display("FAIL collision: got pulse, expected none");
            end else void'(exp_coll.pop_front());
         end
         if (overflow) begin
            checks++;
            if (exp_ovf.size() == 0) begin
               failures++;
               $display("FAIL overflow: got pulse, expected none");
            end else void'(exp_ovf.pop_front());
         end
      end
   end

   // Stimulus helpers; all entered and left at posedge+1
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge sysclk);
         #1;
      end
   endtask

   task automatic drive(input logic [2:0] m);
      {X2_req, X1_req, X0_req} = m;
      cyc(1);
   endtask

   task automatic wait_idle(input string name, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         if (!busy && outs == 3'b000) break;
         cyc(1);
      end
      check(name, (i < bound) ? 1 : 0, 1);
   endtask

   task automatic wait_level(input string name, input int ch, input logic lvl, input int bound);
      int i;
      for (i = 0; i < bound; i++) begin
         if (outs[ch] == lvl) break;
         cyc(1);
      end
      check(name, (i < bound) ? 1 : 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      // Reset state
      #12;
      check("rst_outs", outs, 0);
      check("rst_busy", busy, 0);
      check("rst_collision", collision, 0);
      check("rst_overflow", overflow, 0);
      @(posedge sysclk);
      #1 reset = 1'b1;
      cyc(2);

      // 1: single X1 press, busy through the gap
      push_hold(1, HOLD_LEN);
      drive(3'b010);
      check("t1_busy_after_req", busy, 1);
      drive(3'b000);
      wait_level("t1_rise", 1, 1'b1, 50);
      check("t1_others_low", {outs[2], outs[0]}, 0);
      wait_level("t1_fall", 1, 1'b0, 50);
      n = 0;
      while (busy && n < 100) begin
         cyc(1);
         n++;
      end
      check("t1_busy_gap_cycles", n, GAP_TICKS * TICK_CYC);
      wait_idle("t1_idle", 100);

      // 2: collision, nothing queued
      exp_coll.push_back(2);
      drive(3'b101);
      check("t2_busy", busy, 0);
      drive(3'b000);
      cyc(3);
      check("t2_busy_later", busy, 0);
      check("t2_outs", outs, 0);

      // 3: arrival order X2, X0, X1
      push_hold(2, HOLD_LEN);
      push_hold(0, HOLD_LEN);
      push_hold(1, HOLD_LEN);
      drive(3'b100);
      drive(3'b001);
      drive(3'b010);
      drive(3'b000);
      wait_idle("t3_idle", 300);

      // 4: five X1 presses during an X0 hold, fifth overflows
      push_hold(0, HOLD_LEN);
      drive(3'b001);
      drive(3'b000);
      wait_level("t4_rise", 0, 1'b1, 50);
      for (int i = 0; i < 4; i++) push_hold(1, HOLD_LEN);
      exp_ovf.push_back(4);
      repeat (5) drive(3'b010);
      drive(3'b000);
      check("t4_busy", busy, 1);
      wait_idle("t4_idle", 400);

      // 5: reset mid-hold with two presses queued
      push_hold(0, 0);
      drive(3'b001);
      drive(3'b010);
      drive(3'b100);
      drive(3'b000);
      wait_level("t5_rise", 0, 1'b1, 50);
      cyc(3);
      #2 reset = 1'b0;
      #1;
      check("t5_outs_async", outs, 0);
      check("t5_busy_async", busy, 0);
      cyc(1);
      reset = 1'b1;
      cyc(80);
      check("t5_busy_after", busy, 0);
      check("t5_outs_after", outs, 0);

      // 6: repeat X2 press after the second hold tick
`ifdef STRETCH_REPEAT_EN
      push_hold(2, HOLD_LEN + 2 * TICK_CYC);
`else
      push_hold(2, HOLD_LEN);
      push_hold(2, HOLD_LEN);
`endif
      drive(3'b100);
      drive(3'b000);
      wait_level("t6_rise", 2, 1'b1, 50);
      cyc(7);
      drive(3'b100);
      drive(3'b000);
      wait_idle("t6_idle", 300);

      cyc(4);
      check("end_holds_left", exp_hold.size(), 0);
      check("end_collisions_left", exp_coll.size(), 0);
      check("end_overflows_left", exp_ovf.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
